path_sel_stage: RTL and testbench

PATH_SEL_STAGE -- requirements
Module: path_sel_stage

---
 rtl/path_sel_stage_pkg.sv | 31 +++
 rtl/path_sel_mux.sv | 54 +++++
 rtl/path_sel_stage.sv | 169 ++++++++++++++++
 tb/tb_path_sel_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_sel_stage_pkg.sv
// Shared types for the path-select stage: exponent-class encodings, skid FSM states
// and the packed path word at its default widths.
package path_sel_stage_pkg;

  typedef enum logic [1:0] {
    ECLS_SUB   = 2'b00,
    ECLS_NOR_A = 2'b01,
    ECLS_NOR_B = 2'b10,
    ECLS_SPC   = 2'b11
  } ecls_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int PW_EXP_W = 8;
  localparam int PW_MAN_W = 28;

  // Field order is the order of the output word: sign pair down to the special flag.
  typedef struct packed {
    logic [1:0]          sgn;
    logic                c;
    logic [PW_EXP_W-1:0] e;
    logic [PW_MAN_W-1:0] a;
    logic [PW_MAN_W-1:0] b;
    logic                special;
  } path_word_t;

endpackage

// File: rtl/path_sel_mux.sv
// Combinational class decode: picks the normal or subnormal path fields, or forces
// a zeroed special word that keeps the normal-path signs.
module path_sel_mux
  import path_sel_stage_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
) (
  input  logic [1:0]       ecls,
  input  logic [1:0]       nor_sgn,
  input  logic [1:0]       sub_sgn,
  input  logic             comp_n,
  input  logic             comp_s,
  input  logic [EXP_W-1:0] nor_e,
  input  logic [EXP_W-1:0] sub_e,
  input  logic [MAN_W-1:0] nor_ma,
  input  logic [MAN_W-1:0] nor_mb,
  input  logic [MAN_W-1:0] sub_ma,
  input  logic [MAN_W-1:0] sub_mb,
  output logic [1:0]       sel_sgn,
  output logic             sel_c,
  output logic [EXP_W-1:0] sel_e,
  output logic [MAN_W-1:0] sel_a,
  output logic [MAN_W-1:0] sel_b,
  output logic             sel_special
);

  always_comb begin
    sel_sgn     = nor_sgn;
    sel_c       = comp_n;
    sel_e       = nor_e;
    sel_a       = nor_ma;
    sel_b       = nor_mb;
    sel_special = 1'b0;
    case (ecls_e'(ecls))
      ECLS_SUB: begin
        sel_sgn = sub_sgn;
        sel_c   = comp_s;
        sel_e   = sub_e;
        sel_a   = sub_ma;
        sel_b   = sub_mb;
      end
      ECLS_SPC: begin
        sel_c       = 1'b0;
        sel_e       = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_special = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/path_sel_stage.sv
// Path-select stage: class mux feeding a two-entry skid buffer (EMPTY/ONE/TWO).
// Define PATH_SEL_STATS_EN to add per-class saturating accept counters with cnt_clr.
module path_sel_stage
  import path_sel_stage_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ecls,
  input  logic [1:0]       nor_sgn,
  input  logic [1:0]       sub_sgn,
  input  logic             comp_n,
  input  logic             comp_s,
  input  logic [EXP_W-1:0] nor_e,
  input  logic [EXP_W-1:0] sub_e,
  input  logic [MAN_W-1:0] nor_ma,
  input  logic [MAN_W-1:0] nor_mb,
  input  logic [MAN_W-1:0] sub_ma,
  input  logic [MAN_W-1:0] sub_mb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sgn,
  output logic             out_c,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_a,
  output logic [MAN_W-1:0] out_b,
  output logic             out_special,
  output logic [1:0]       dbg_state
`ifdef PATH_SEL_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_nor,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_spc
`endif
);

  typedef struct packed {
    logic [1:0]       sgn;
    logic             c;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] a;
    logic [MAN_W-1:0] b;
    logic             special;
  } word_t;

  word_t  in_word;
  word_t  out_q, skid_q;
  state_e state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   push, pop;
  logic   load_out, load_skid, out_from_skid;

  path_sel_mux #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mux (
    .ecls        (ecls),
    .nor_sgn     (nor_sgn),
    .sub_sgn     (sub_sgn),
    .comp_n      (comp_n),
    .comp_s      (comp_s),
    .nor_e       (nor_e),
    .sub_e       (sub_e),
    .nor_ma      (nor_ma),
    .nor_mb      (nor_mb),
    .sub_ma      (sub_ma),
    .sub_mb      (sub_mb),
    .sel_sgn     (in_word.sgn),
    .sel_c       (in_word.c),
    .sel_e       (in_word.e),
    .sel_a       (in_word.a),
    .sel_b       (in_word.b),
    .sel_special (in_word.special)
  );

  // Handshake: a word moves on a port in any cycle where its valid and ready are both high.
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: if (push) begin
        state_d  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_out = 1'b1;
        end
      end
      TWO: if (pop) begin
        state_d       = ONE;
        out_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready stays low through the first edge after reset, then tracks "not full".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      if (load_out)
        out_q <= in_word;
      else if (out_from_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= in_word;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sgn     = out_q.sgn;
  assign out_c       = out_q.c;
  assign out_e       = out_q.e;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_special = out_q.special;
  assign dbg_state   = state_q;

`ifdef PATH_SEL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] cnt_nor_q, cnt_sub_q, cnt_spc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_nor_q <= '0;
      cnt_sub_q <= '0;
      cnt_spc_q <= '0;
    end else if (cnt_clr) begin
      cnt_nor_q <= '0;
      cnt_sub_q <= '0;
      cnt_spc_q <= '0;
    end else if (push) begin
      case (ecls_e'(ecls))
        ECLS_SUB: if (cnt_sub_q != '1) cnt_sub_q <= cnt_sub_q + CNT_ONE;
        ECLS_SPC: if (cnt_spc_q != '1) cnt_spc_q <= cnt_spc_q + CNT_ONE;
        default:  if (cnt_nor_q != '1) cnt_nor_q <= cnt_nor_q + CNT_ONE;
      endcase
    end
  end

  assign cnt_nor = cnt_nor_q;
  assign cnt_sub = cnt_sub_q;
  assign cnt_spc = cnt_spc_q;
`endif

endmodule

// File: tb/tb_path_sel_stage.sv
// Bench for path_sel_stage: directed scenarios plus random valid/ready traffic, checked
// against a queue-based reference of the stage contents.
module tb_path_sel_stage;
  import path_sel_stage_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 28;
`ifdef PATH_SEL_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int W = $bits(path_word_t);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       ecls, nor_sgn, sub_sgn, out_sgn, dbg_state;
  logic             comp_n, comp_s, out_c, out_special;
  logic [EXP_W-1:0] nor_e, sub_e, out_e;
  logic [MAN_W-1:0] nor_ma, nor_mb, sub_ma, sub_mb, out_a, out_b;
`ifdef PATH_SEL_STATS_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_nor, cnt_sub, cnt_spc;
`endif

  path_sel_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ecls(ecls), .nor_sgn(nor_sgn), .sub_sgn(sub_sgn),
    .comp_n(comp_n), .comp_s(comp_s), .nor_e(nor_e), .sub_e(sub_e),
    .nor_ma(nor_ma), .nor_mb(nor_mb), .sub_ma(sub_ma), .sub_mb(sub_mb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sgn(out_sgn), .out_c(out_c), .out_e(out_e), .out_a(out_a),
    .out_b(out_b), .out_special(out_special), .dbg_state(dbg_state)
`ifdef PATH_SEL_STATS_EN
    , .cnt_clr(cnt_clr), .cnt_nor(cnt_nor), .cnt_sub(cnt_sub), .cnt_spc(cnt_spc)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_shown;
  bit           m_ready;
  int           m_cnt[3];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected word for whatever is currently on the inputs, straight from the class rules.
  function automatic logic [W-1:0] ref_word();
    path_word_t w;
    if (ecls == 2'b11)
      w = '{sgn: nor_sgn, c: 1'b0, e: '0, a: '0, b: '0, special: 1'b1};
    else if (ecls == 2'b00)
      w = '{sgn: sub_sgn, c: comp_s, e: sub_e, a: sub_ma, b: sub_mb, special: 1'b0};
    else
      w = '{sgn: nor_sgn, c: comp_n, e: nor_e, a: nor_ma, b: nor_mb, special: 1'b0};
    return w;
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {out_sgn, out_c, out_e, out_a, out_b, out_special};
  endfunction

  task automatic check_outputs();
    chk("in_ready", 128'(in_ready), 128'(m_ready));
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_word", 128'(obs_word()), 128'(exp_q[0]));
      last_shown = exp_q[0];
    end else begin
      chk("idle_hold", 128'(obs_word()), 128'(last_shown));
    end
`ifdef PATH_SEL_STATS_EN
    chk("cnt_nor", 128'(cnt_nor), 128'(m_cnt[0]));
    chk("cnt_sub", 128'(cnt_sub), 128'(m_cnt[1]));
    chk("cnt_spc", 128'(cnt_spc), 128'(m_cnt[2]));
`endif
  endtask

  // One clock: predict the transfers from the pre-edge inputs, then compare after the edge.
  task automatic cycle(output bit acc);
    logic [W-1:0] w;
    logic [1:0]   cls;
    bit           pop, clr;
    acc = in_valid && m_ready;
    pop = (exp_q.size() > 0) && out_ready;
    w   = ref_word();
    cls = ecls;
    clr = 1'b0;
`ifdef PATH_SEL_STATS_EN
    clr = cnt_clr;
`endif
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(w);
    if (clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
    end else if (acc) begin
      int k;
      k = (cls == 2'b00) ? 1 : (cls == 2'b11) ? 2 : 0;
      if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
    end
    m_ready = (exp_q.size() < 2);
    check_outputs();
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
`ifdef PATH_SEL_STATS_EN
    cnt_clr = 1'b0;
`endif
    #1;
    exp_q.delete();
    last_shown = '0;
    m_ready = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drive_push();
    bit acc;
    int n;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(acc);
      n++;
    end
    in_valid = 1'b0;
    chk("push_accept", 128'(acc), 128'(1));
  endtask

  task automatic rand_inputs();
    ecls    = 2'($urandom_range(0, 3));
    nor_sgn = 2'($urandom_range(0, 3));
    sub_sgn = 2'($urandom_range(0, 3));
    comp_n  = 1'($urandom_range(0, 1));
    comp_s  = 1'($urandom_range(0, 1));
    nor_e   = EXP_W'($urandom);
    sub_e   = EXP_W'($urandom);
    nor_ma  = MAN_W'($urandom);
    nor_mb  = MAN_W'($urandom);
    sub_ma  = MAN_W'($urandom);
    sub_mb  = MAN_W'($urandom);
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rand_inputs();
`ifdef PATH_SEL_STATS_EN
    cnt_clr = 1'b0;
`endif
    #1;
    do_reset();

    // normal path word, one-cycle latency
    out_ready = 1'b1;
    rand_inputs();
    ecls = 2'b01; nor_e = 8'h7F; nor_ma = 28'h1234567;
    drive_push();
    chk("r27_valid", 128'(out_valid), 128'(1));
    chk("r27_e", 128'(out_e), 128'(8'h7F));
    chk("r27_a", 128'(out_a), 128'(28'h1234567));
    chk("r27_spc", 128'(out_special), 128'(0));

    // subnormal path word
    rand_inputs();
    ecls = 2'b00; sub_e = 8'h00; comp_s = 1'b1; comp_n = 1'b0;
    drive_push();
    chk("r28_c", 128'(out_c), 128'(1));
    chk("r28_e", 128'(out_e), 128'(8'h00));
    chk("r28_a", 128'(out_a), 128'(sub_ma));
    chk("r28_b", 128'(out_b), 128'(sub_mb));

    // special word with nonzero path inputs
    rand_inputs();
    ecls = 2'b11; nor_e = 8'hA5; nor_ma = 28'hFFFFFFF; nor_mb = 28'h0ABCDEF; comp_n = 1'b1;
    drive_push();
    chk("r29_spc", 128'(out_special), 128'(1));
    chk("r29_a", 128'(out_a), 128'(0));
    chk("r29_b", 128'(out_b), 128'(0));
    chk("r29_e", 128'(out_e), 128'(0));
    idle(3);

    // back-pressure: two accepted, third held off, then drained in order
    out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      rand_inputs(); ecls = 2'b10; nor_e = EXP_W'(i);
      drive_push();
    end
    rand_inputs(); ecls = 2'b10; nor_e = 8'd3;
    in_valid = 1'b1;
    idle(3);
    chk("r30_full", 128'(in_ready), 128'(0));
    chk("r30_head", 128'(out_e), 128'(8'd1));
    out_ready = 1'b1;
    drive_push();
    idle(4);

    // reset while full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      drive_push();
    end
    chk("r31_two", 128'(dbg_state), 128'(2));
    do_reset();
    out_ready = 1'b1;
    rand_inputs();
    drive_push();
    idle(2);

`ifdef PATH_SEL_STATS_EN
    // counter saturation and clear-over-increment
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_inputs(); ecls = 2'b01;
      drive_push();
    end
    chk("r32_sat", 128'(cnt_nor), 128'(4'hF));
    rand_inputs(); ecls = 2'b10;
    cnt_clr = 1'b1;
    drive_push();
    cnt_clr = 1'b0;
    chk("r32_clr", 128'(cnt_nor), 128'(0));
    idle(2);
`endif

    // random traffic, with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef PATH_SEL_STATS_EN
      cnt_clr = ($urandom_range(0, 49) == 0);
`endif
      if (i == 700) do_reset();
      else cycle(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef PATH_SEL_STATS_EN
    cnt_clr = 1'b0;
`endif
    idle(4);
    chk("drained", 128'(exp_q.size()), 128'(0));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
